// File: rtl/composer_pkg.sv
// composer_pkg: shared definitions for the piano composer datapath.
// Holds the note code width, the note code map (0 = rest, C4..C5 chromatic),
// the playback sequencer state encoding and the default note slot length.
// No ports.
package composer_pkg;

  localparam int NOTE_W             = 5;
  localparam int TICKS_PER_NOTE_DEF = 8;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 5'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS4  = 5'd2;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 5'd3;
  localparam logic [NOTE_W-1:0] NOTE_DS4  = 5'd4;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 5'd5;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 5'd6;
  localparam logic [NOTE_W-1:0] NOTE_FS4  = 5'd7;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 5'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS4  = 5'd9;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 5'd10;
  localparam logic [NOTE_W-1:0] NOTE_AS4  = 5'd11;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 5'd12;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 5'd13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SOUND  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/note_ram.sv
// note_ram: DEPTH x NOTE_W note store. Synchronous write, asynchronous read,
// no reset (contents are don't-care until written).
// Ports:
//   clk_i   - system clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - note code to store
//   raddr_i - read address
//   rdata_o - note code at raddr_i (combinational)
module note_ram
  import composer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [NOTE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [NOTE_W-1:0] rdata_o
);

  logic [NOTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/score_sequencer.sv
// score_sequencer: note store and playback sequencer between the PS/2 note
// decoder and the piano tone generator.
// In IDLE, notes are appended (insert_en && note_valid) or the last note is
// removed (delete_en). On play_en the stored notes are streamed out, each note
// taking TICKS_PER_NOTE tick strobes: TICKS_PER_NOTE-1 sounding, 1 silent gap.
// Optional build macro: LOOP_PLAY_EN -- when defined, playback wraps back to the
// first note while play_en is still high at the end of the last note.
// Ports:
//   CLOCK_50        in   system clock
//   reset           in   asynchronous active-high reset
//   tick            in   one-cycle 16 Hz strobe
//   note_valid      in   note_code strobe
//   note_code       in   decoded key (0 = rest)
//   insert_en       in   record mode level
//   delete_en       in   remove-last-note request
//   play_en         in   play request level
//   insert_ack      out  one-cycle pulse, a note was stored
//   is_full         out  count == DEPTH
//   is_empty        out  count == 0
//   count           out  stored note count
//   play_active     out  high in SOUND or GAP
//   play_note       out  note to the tone generator
//   play_note_valid out  tone generator should sound play_note
//   play_done       out  one-cycle pulse, playback finished
//
// state  | meaning
// IDLE   | editing allowed, waiting for play_en
// SOUND  | current note sounding, counting ticks
// GAP    | one-tick silent articulation gap after each note
// FINISH | playback over, waiting for play_en to drop
module score_sequencer
  import composer_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int TICKS_PER_NOTE = TICKS_PER_NOTE_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              tick,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_code,
  input  logic              insert_en,
  input  logic              delete_en,
  input  logic              play_en,
  output logic              insert_ack,
  output logic              is_full,
  output logic              is_empty,
  output logic [ADDR_W:0]   count,
  output logic              play_active,
  output logic [NOTE_W-1:0] play_note,
  output logic              play_note_valid,
  output logic              play_done
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int TCNT_W = (TICKS_PER_NOTE > 2) ? $clog2(TICKS_PER_NOTE) : 1;

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic [TCNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [NOTE_W-1:0] play_note_q, play_note_d;
  logic              insert_ack_q, insert_ack_d;
  logic              play_done_q, play_done_d;

  logic              ram_we;
  logic [NOTE_W-1:0] ram_rdata;
  logic              full, empty, last_note;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign last_note = ({1'b0, rd_idx_q} == (count_q - CNT_W'(1)));

  // Read address follows the next rd_idx so play_note is registered in the
  // same edge that enters (or re-enters) SOUND.
  note_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_note_ram (
    .clk_i   (CLOCK_50),
    .we_i    (ram_we),
    .waddr_i (count_q[ADDR_W-1:0]),
    .wdata_i (note_code),
    .raddr_i (rd_idx_d),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rd_idx_q     <= '0;
      tick_cnt_q   <= '0;
      play_note_q  <= '0;
      insert_ack_q <= 1'b0;
      play_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_idx_q     <= rd_idx_d;
      tick_cnt_q   <= tick_cnt_d;
      play_note_q  <= play_note_d;
      insert_ack_q <= insert_ack_d;
      play_done_q  <= play_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_idx_d     = rd_idx_q;
    tick_cnt_d   = tick_cnt_q;
    insert_ack_d = 1'b0;
    play_done_d  = 1'b0;
    ram_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Delete has priority over a same-cycle insert.
        if (delete_en && !empty) begin
          count_d = count_q - CNT_W'(1);
        end else if (insert_en && note_valid && !full) begin
          ram_we       = 1'b1;
          count_d      = count_q + CNT_W'(1);
          insert_ack_d = 1'b1;
        end
        if (play_en) begin
          if (empty) begin
            state_d     = FINISH;
            play_done_d = 1'b1;
          end else begin
            state_d    = SOUND;
            rd_idx_d   = '0;
            tick_cnt_d = '0;
          end
        end
      end
      SOUND: begin
        if (tick) begin
          if (tick_cnt_q == TCNT_W'(TICKS_PER_NOTE - 2)) state_d = GAP;
          else tick_cnt_d = tick_cnt_q + TCNT_W'(1);
        end
      end
      GAP: begin
        if (tick) begin
          if (last_note) begin
`ifdef LOOP_PLAY_EN
            if (play_en) begin
              state_d    = SOUND;
              rd_idx_d   = '0;
              tick_cnt_d = '0;
            end else begin
              state_d     = FINISH;
              play_done_d = 1'b1;
            end
`else
            state_d     = FINISH;
            play_done_d = 1'b1;
`endif
          end else begin
            state_d    = SOUND;
            rd_idx_d   = rd_idx_q + ADDR_W'(1);
            tick_cnt_d = '0;
          end
        end
      end
      FINISH: begin
        // Holding play_en here keeps a level-held request from retriggering.
        if (!play_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    play_note_d = (state_d == SOUND) ? ram_rdata : '0;
  end

  assign insert_ack      = insert_ack_q;
  assign is_full         = full;
  assign is_empty        = empty;
  assign count           = count_q;
  assign play_active     = (state_q == SOUND) || (state_q == GAP);
  assign play_note       = play_note_q;
  assign play_note_valid = (state_q == SOUND) && (play_note_q != '0);
  assign play_done       = play_done_q;

endmodule

// File: tb/tb_score_sequencer.sv
module tb_score_sequencer;
  import composer_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic              tick = 1'b0;
  logic              note_valid = 1'b0;
  logic [NOTE_W-1:0] note_code = '0;
  logic              insert_en = 1'b0;
  logic              delete_en = 1'b0;
  logic              play_en = 1'b0;
  logic              insert_ack;
  logic              is_full;
  logic              is_empty;
  logic [ADDR_W:0]   count;
  logic              play_active;
  logic [NOTE_W-1:0] play_note;
  logic              play_note_valid;
  logic              play_done;

  int checks = 0;
  int passed = 0;

  score_sequencer #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .TICKS_PER_NOTE (8)
  ) dut (
    .CLOCK_50        (CLOCK_50),
    .reset           (reset),
    .tick            (tick),
    .note_valid      (note_valid),
    .note_code       (note_code),
    .insert_en       (insert_en),
    .delete_en       (delete_en),
    .play_en         (play_en),
    .insert_ack      (insert_ack),
    .is_full         (is_full),
    .is_empty        (is_empty),
    .count           (count),
    .play_active     (play_active),
    .play_note       (play_note),
    .play_note_valid (play_note_valid),
    .play_done       (play_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers (no checking).
  task automatic do_reset();
    reset = 1'b1; tick = 0; note_valid = 0; insert_en = 0; delete_en = 0; play_en = 0;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
  endtask

  task automatic insert_raw(input logic [NOTE_W-1:0] code);
    note_code = code; insert_en = 1'b1; note_valid = 1'b1;
    @(posedge CLOCK_50); #1;
    note_valid = 1'b0; insert_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    checks++;
    if (count !== 0 || is_empty !== 1 || is_full !== 0) $display("FAIL reset_count: count=%0d empty=%0b full=%0b expected 0/1/0", count, is_empty, is_full);
    else passed++;
    checks++;
    if (insert_ack !== 0 || play_done !== 0 || play_active !== 0 || play_note !== 0 || play_note_valid !== 0)
      $display("FAIL reset_outputs: ack=%0b done=%0b active=%0b note=%0d valid=%0b expected all 0", insert_ack, play_done, play_active, play_note, play_note_valid);
    else passed++;
    reset = 1'b0;
    @(posedge CLOCK_50); #1;
    delete_en = 1'b1;
    @(posedge CLOCK_50); #1;
    delete_en = 1'b0;
    checks++;
    if (count !== 0 || is_empty !== 1) $display("FAIL delete_empty: count=%0d empty=%0b expected 0/1", count, is_empty);
    else passed++;
  endtask

  task automatic test_insert();
    logic [NOTE_W-1:0] codes [3] = '{NOTE_C4, NOTE_D4, NOTE_E4};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      insert_raw(codes[i]);
      checks++;
      if (insert_ack !== 1'b1) $display("FAIL insert_ack[%0d]: got %0b expected 1", i, insert_ack);
      else passed++;
    end
    @(posedge CLOCK_50); #1;
    checks++;
    if (insert_ack !== 1'b0) $display("FAIL insert_ack_drop: got %0b expected 0", insert_ack);
    else passed++;
    checks++;
    if (count !== 3 || is_empty !== 0) $display("FAIL insert_count: count=%0d empty=%0b expected 3/0", count, is_empty);
    else passed++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      insert_raw(NOTE_W'(i % 13 + 1));
      checks++;
      if (insert_ack !== (i < 16)) $display("FAIL full_ack[%0d]: got %0b expected %0b", i, insert_ack, (i < 16));
      else passed++;
    end
    checks++;
    if (count !== 16 || is_full !== 1) $display("FAIL full_count: count=%0d full=%0b expected 16/1", count, is_full);
    else passed++;
    delete_en = 1'b1;
    @(posedge CLOCK_50); #1;
    delete_en = 1'b0;
    checks++;
    if (count !== 15 || is_full !== 0) $display("FAIL full_delete: count=%0d full=%0b expected 15/0", count, is_full);
    else passed++;
  endtask

  task automatic test_play();
    logic [NOTE_W-1:0] exp_q [$];
    logic [NOTE_W-1:0] codes [3] = '{NOTE_C4, NOTE_REST, NOTE_E4};
    logic [NOTE_W-1:0] cur;
    int n, done_pulses, done_at, last_slot;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      insert_raw(codes[i]);
      exp_q.push_back(codes[i]);
    end
    play_en = 1'b1;
    @(posedge CLOCK_50); #1;
    n = 0; done_pulses = 0; done_at = -1; last_slot = -1; cur = '0;
    for (int c = 0; c < 130; c++) begin
`ifdef LOOP_PLAY_EN
      if (c == 40) play_en = 1'b0;
`endif
      if (n < 24) begin
        if (n / 8 != last_slot) begin
          last_slot = n / 8;
          cur = exp_q.pop_front();
        end
        checks++;
        if (play_active !== 1'b1) $display("FAIL play_active c=%0d n=%0d: got %0b expected 1", c, n, play_active);
        else passed++;
        if (n % 8 < 7) begin
          checks++;
          if (play_note !== cur) $display("FAIL play_note c=%0d n=%0d: got %0d expected %0d", c, n, play_note, cur);
          else passed++;
          checks++;
          if (play_note_valid !== (cur != '0)) $display("FAIL play_valid c=%0d n=%0d: got %0b expected %0b", c, n, play_note_valid, (cur != '0));
          else passed++;
        end else begin
          checks++;
          if (play_note_valid !== 1'b0) $display("FAIL gap_valid c=%0d n=%0d: got %0b expected 0", c, n, play_note_valid);
          else passed++;
        end
      end else begin
        checks++;
        if (play_active !== 1'b0 || play_note_valid !== 1'b0)
          $display("FAIL finish_hold c=%0d: active=%0b valid=%0b expected 0/0", c, play_active, play_note_valid);
        else passed++;
      end
      if (play_done === 1'b1) begin
        done_pulses++;
        if (done_at < 0) done_at = n;
      end
      tick = (c % 4 == 3);
      @(posedge CLOCK_50); #1;
      if (tick) n++;
      tick = 1'b0;
    end
    checks++;
    if (done_pulses != 1 || done_at != 24) $display("FAIL play_done: pulses=%0d at_tick=%0d expected 1 at 24", done_pulses, done_at);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL play_slots: %0d notes not played, expected 0", exp_q.size());
    else passed++;
    play_en = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 insert_raw(NOTE_G4);
    checks++;
    if (insert_ack !== 1'b1 || count !== 4) $display("FAIL after_finish_insert: ack=%0b count=%0d expected 1/4", insert_ack, count);
    else passed++;
  endtask

  task automatic test_play_empty();
    do_reset();
    play_en = 1'b1;
    @(posedge CLOCK_50); #1;
    checks++;
    if (play_done !== 1'b1) $display("FAIL empty_done: got %0b expected 1", play_done);
    else passed++;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLOCK_50); #1;
      checks++;
      if (play_done !== 0 || play_note_valid !== 0 || play_active !== 0)
        $display("FAIL empty_hold c=%0d: done=%0b valid=%0b active=%0b expected 0/0/0", c, play_done, play_note_valid, play_active);
      else passed++;
    end
    play_en = 1'b0;
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_reset_mid_play();
    int n;
    do_reset();
    insert_raw(NOTE_CS4);
    insert_raw(NOTE_DS4);
    insert_raw(NOTE_F4);
    play_en = 1'b1;
    @(posedge CLOCK_50); #1;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      tick = (c % 4 == 3);
      @(posedge CLOCK_50); #1;
      if (tick) n++;
      tick = 1'b0;
    end
    checks++;
    if (play_note !== NOTE_DS4 || play_note_valid !== 1'b1) $display("FAIL mid_note: note=%0d valid=%0b expected %0d/1", play_note, play_note_valid, NOTE_DS4);
    else passed++;
    delete_en = 1'b1; insert_en = 1'b1; note_valid = 1'b1; note_code = NOTE_A4;
    @(posedge CLOCK_50); #1;
    delete_en = 1'b0; insert_en = 1'b0; note_valid = 1'b0;
    checks++;
    if (count !== 3 || insert_ack !== 1'b0) $display("FAIL edit_in_play: count=%0d ack=%0b expected 3/0", count, insert_ack);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (count !== 0 || is_empty !== 1 || play_active !== 0 || play_note !== 0 || play_note_valid !== 0 || play_done !== 0 || insert_ack !== 0)
      $display("FAIL async_reset: count=%0d empty=%0b active=%0b note=%0d valid=%0b done=%0b ack=%0b", count, is_empty, play_active, play_note, play_note_valid, play_done, insert_ack);
    else passed++;
    play_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLOCK_50); #1;
      checks++;
      if (play_done !== 1'b0) $display("FAIL reset_no_done c=%0d: got %0b expected 0", c, play_done);
      else passed++;
    end
    reset = 1'b0;
    @(posedge CLOCK_50); #1;
    insert_raw(NOTE_FS4);
    checks++;
    if (insert_ack !== 1'b1 || count !== 1) $display("FAIL post_reset_insert: ack=%0b count=%0d expected 1/1", insert_ack, count);
    else passed++;
    play_en = 1'b1;
    @(posedge CLOCK_50); #1;
    checks++;
    if (play_note !== NOTE_FS4) $display("FAIL post_reset_addr0: note=%0d expected %0d", play_note, NOTE_FS4);
    else passed++;
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) insert_raw(NOTE_W'(i + 1));
    checks++;
    if (count !== 4) $display("FAIL b2b_setup: count=%0d expected 4", count);
    else passed++;
    delete_en = 1'b1; insert_en = 1'b1; note_valid = 1'b1; note_code = NOTE_B4;
    @(posedge CLOCK_50); #1;
    delete_en = 1'b0; insert_en = 1'b0; note_valid = 1'b0;
    checks++;
    if (count !== 3 || insert_ack !== 1'b0) $display("FAIL delete_wins: count=%0d ack=%0b expected 3/0", count, insert_ack);
    else passed++;
  endtask

`ifdef LOOP_PLAY_EN
  task automatic test_loop();
    int n, done_pulses;
    bit wrapped_checked, seen_done;
    play_en = 1'b1;
    @(posedge CLOCK_50); #1;
    n = 0; done_pulses = 0; wrapped_checked = 0;
    for (int c = 0; c < 140; c++) begin
      if (n == 24 && !wrapped_checked) begin
        wrapped_checked = 1;
        checks++;
        if (play_note !== 5'd1 || play_active !== 1'b1) $display("FAIL loop_wrap: note=%0d active=%0b expected 1/1", play_note, play_active);
        else passed++;
      end
      if (play_done === 1'b1) done_pulses++;
      tick = (c % 4 == 3);
      @(posedge CLOCK_50); #1;
      if (tick) n++;
      tick = 1'b0;
    end
    checks++;
    if (done_pulses != 0) $display("FAIL loop_no_done: pulses=%0d expected 0", done_pulses);
    else passed++;
    play_en = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (play_done === 1'b1) seen_done = 1;
      tick = (c % 4 == 3);
      @(posedge CLOCK_50); #1;
      tick = 1'b0;
    end
    checks++;
    if (!seen_done) $display("FAIL loop_stop_done: no play_done within budget, expected one");
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_insert();
    test_full();
    test_play();
    test_play_empty();
    test_reset_mid_play();
    test_back_to_back();
`ifdef LOOP_PLAY_EN
    test_loop();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
